// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, bit timing and the
// transmit-arbiter state encoding.
package uart_pkg;

   localparam int UART_DATA_W  = 8;
   localparam int SYS_CLK_HZ   = 50_000_000;
   localparam int UART_BAUD    = 115_200;
   localparam int CLKS_PER_BIT = SYS_CLK_HZ / UART_BAUD;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   function automatic int rr_next(input int cur, input int n);
      return (cur + 1) % n;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending request
// strictly after the last granted index, wrapping mod N_REQ.
module rr_pick
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    win,
   output logic             valid
);

   int idx;

   always_comb begin
      win   = last;
      valid = 1'b0;
      idx   = int'(last);
      for (int i = 0; i < N_REQ; i++) begin
         idx = rr_next(idx, N_REQ);
         if (!valid && req[IW'(idx)]) begin
            win   = IW'(idx);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ
// byte requesters, with a watchdog against a stalled transmitter.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = UART_DATA_W,
   parameter int TIMEOUT_CYC = 65535,
   parameter int IW          = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic                    tx_start,
   output logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_busy,
   input  logic                    tx_done,
   output logic [IW-1:0]           grant_id,
   output logic                    active,
   output logic                    timeout
);

   localparam int CNT_W = (TIMEOUT_CYC > 0) ?
                          $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX =
      CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC : 1);

   arb_state_e        state_q, state_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              start_q, start_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IW-1:0]     gid_q, gid_d;
   logic              active_q, active_d;
   logic              tmo_q, tmo_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [IW-1:0]     pick_id;
   logic              pick_valid;
   logic              expire;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req   (req),
      .last  (gid_q),
      .win   (pick_id),
      .valid (pick_valid)
   );

   // cnt_q holds cycles elapsed since the tx_start cycle
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign expire  = (TIMEOUT_CYC != 0) &&
                    (int'(cnt_q) >= TIMEOUT_CYC - 1);

   always_comb begin
      state_d = state_q;
      ack_d   = '0;
      start_d = 1'b0;
      data_d  = data_q;
      gid_d   = gid_q;
      tmo_d   = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (pick_valid && !tx_busy) begin
               data_d         = req_data[int'(pick_id)*DATA_W +: DATA_W];
               gid_d          = pick_id;
               ack_d[pick_id] = 1'b1;
               start_d        = 1'b1;
               state_d        = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = cnt_inc;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_inc;
            if (tx_done) begin
               state_d = ST_IDLE;
            end else if (expire) begin
               tmo_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      active_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ack_q    <= '0;
         start_q  <= 1'b0;
         data_q   <= '0;
         gid_q    <= IW'(N_REQ - 1);
         active_q <= 1'b0;
         tmo_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         start_q  <= start_d;
         data_q   <= data_d;
         gid_q    <= gid_d;
         active_q <= active_d;
         tmo_q    <= tmo_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ack      = ack_q;
   assign tx_start = start_q;
   assign tx_data  = data_q;
   assign grant_id = gid_q;
   assign active   = active_q;
   assign timeout  = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed checks of uart_tx_arbiter against a simple uart_tx
// model (20 ns clock, 10-cycle frames, 100-cycle watchdog).
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int TMO   = 100;
   localparam int FRAME = 10;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    ack;
   logic            tx_start;
   logic [DW-1:0]   tx_data;
   logic            tx_busy, tx_done;
   logic [1:0]      grant_id;
   logic            active, timeout;

   logic m_busy, m_done, f_busy, f_done, model_on;
   int   errs, checks;

   assign tx_busy = m_busy | f_busy;
   assign tx_done = m_done | f_done;

   uart_tx_arbiter #(
      .N_REQ       (N),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .grant_id (grant_id),
      .active   (active),
      .timeout  (timeout)
   );

   always #10 clk = ~clk;

   // uart_tx model: busy for FRAME cycles, then a done pulse
   initial begin
      m_busy = 1'b0;
      m_done = 1'b0;
      forever begin
         @(negedge clk);
         if (model_on && tx_start) begin
            m_busy = 1'b1;
            repeat (FRAME) @(negedge clk);
            m_busy = 1'b0;
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
         end
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_start(input int max);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!tx_start && n < max);
      if (!tx_start) check("start_seen", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (active && n < max) begin
         tick();
         n++;
      end
      if (active) check("idle_seen", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   initial begin
      int cnt;
      logic saw;
      logic stable;
      errs     = 0;
      checks   = 0;
      model_on = 1'b1;
      f_busy   = 1'b0;
      f_done   = 1'b0;
      req      = '0;
      req_data = '0;
      rst      = 1'b1;
      repeat (2) tick();
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_start", 32'(tx_start), 32'h0);
      check("rst_data", 32'(tx_data), 32'h0);
      check("rst_gid", 32'(grant_id), 32'd3);
      check("rst_active", 32'(active), 32'h0);
      check("rst_tmo", 32'(timeout), 32'h0);
      rst = 1'b0;
      tick();

      // 1: single request
      req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
      req      = 4'b0100;
      tick();
      check("t1_ack", 32'(ack), 32'h4);
      check("t1_start", 32'(tx_start), 32'h1);
      check("t1_data", 32'(tx_data), 32'hA5);
      check("t1_gid", 32'(grant_id), 32'd2);
      req    = '0;
      cnt    = 1;
      stable = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (!active) break;
         cnt++;
         if (tx_data !== 8'hA5) stable = 1'b0;
      end
      check("t1_active_len", 32'(cnt), 32'(FRAME + 1));
      check("t1_stable", 32'(stable), 32'h1);
      repeat (2) tick();

      // 2: all four continuously requesting
      do_reset();
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req      = 4'hF;
      for (int f = 0; f < 5; f++) begin
         wait_start(40);
         check($sformatf("t2_data%0d", f), 32'(tx_data),
               32'h10 + 32'(f % 4));
         check($sformatf("t2_ack%0d", f), 32'(ack),
               32'h1 << (f % 4));
      end
      req = '0;
      wait_idle(40);
      repeat (3) tick();

      // 3: foreign frame in progress blocks the start
      model_on = 1'b0;
      f_busy   = 1'b1;
      req      = 4'b0001;
      saw      = 1'b0;
      repeat (5) begin
         tick();
         if (tx_start) saw = 1'b1;
      end
      check("t3_no_start", 32'(saw), 32'h0);
      f_busy = 1'b0;
      tick();
      check("t3_start", 32'(tx_start), 32'h1);
      check("t3_ack", 32'(ack), 32'h1);
      req = '0;
      tick();
      f_done = 1'b1;
      tick();
      f_done = 1'b0;
      check("t3_idle", 32'(active), 32'h0);
      check("t3_tmo", 32'(timeout), 32'h0);
      repeat (2) tick();

      // 4: stalled transmitter trips the watchdog
      req_data = {8'hC3, 8'h00, 8'h3C, 8'h00};
      req      = 4'b0010;
      tick();
      check("t4_start", 32'(tx_start), 32'h1);
      check("t4_data", 32'(tx_data), 32'h3C);
      req = 4'b1000;
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!timeout && cnt < 150);
      check("t4_tmo_cyc", 32'(cnt), 32'(TMO));
      check("t4_tmo_idle", 32'(active), 32'h0);
      tick();
      check("t4_tmo_pulse", 32'(timeout), 32'h0);
      check("t4_next_start", 32'(tx_start), 32'h1);
      check("t4_next_ack", 32'(ack), 32'h8);
      check("t4_next_data", 32'(tx_data), 32'hC3);
      check("t4_next_gid", 32'(grant_id), 32'd3);
      req = '0;

      // 6: done arrives in the expiry cycle
      repeat (TMO - 1) tick();
      f_done = 1'b1;
      tick();
      f_done = 1'b0;
      check("t6_tmo", 32'(timeout), 32'h0);
      check("t6_idle", 32'(active), 32'h0);
      tick();
      check("t6_tmo_late", 32'(timeout), 32'h0);

      // 5: reset during WAIT
      req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
      req      = 4'b0100;
      tick();
      check("t5_start", 32'(tx_start), 32'h1);
      req = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("t5_ack", 32'(ack), 32'h0);
      check("t5_start0", 32'(tx_start), 32'h0);
      check("t5_data", 32'(tx_data), 32'h0);
      check("t5_gid", 32'(grant_id), 32'd3);
      check("t5_active", 32'(active), 32'h0);
      rst = 1'b0;
      saw = 1'b0;
      repeat (TMO + 10) begin
         tick();
         if (timeout || ack != '0) saw = 1'b1;
      end
      check("t5_quiet", 32'(saw), 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
